// File: rtl/proc_zbt_writer_pkg.sv
// Shared widths, constants and queue entry type for the processed-pixel ZBT write stage.
package proc_zbt_writer_pkg;

  localparam int PIX_PAIR_W = 36;
  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_WR_LAT = 2;

  // Outside the frame, so it doubles as "no previous address" after reset.
  localparam logic [ZBT_ADDR_W-1:0] ADDR_NONE = 19'h7FFFF;

  typedef struct packed {
    logic [ZBT_ADDR_W-1:0] addr;
    logic [PIX_PAIR_W-1:0] data;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/proc_wr_fifo.sv
// Small synchronous FIFO; a push into a full FIFO only succeeds alongside a pop.
module proc_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 55,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/proc_zbt_writer.sv
// Queues processed pixel pairs per distinct address and writes them to ZBT bank 1 in free slots.
// Optional PROC_WR_DROPCNT_EN adds the saturating drop_count port.
module proc_zbt_writer
  import proc_zbt_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIX_PAIR_W-1:0] two_proc_pixs,
  input  logic [ZBT_ADDR_W-1:0] proc_pix_addr,
  input  logic                  wr_enable,
  input  logic                  zbt_rd_slot,
  output logic [ZBT_ADDR_W-1:0] zbt_addr,
  output logic                  zbt_we,
  output logic [PIX_PAIR_W-1:0] zbt_wdata,
  output logic                  fifo_full,
  output logic                  overflow
`ifdef PROC_WR_DROPCNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wr_entry_t         push_ent, pop_ent;
  logic              fifo_empty, fifo_full_w;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              cap, push, pop, drop;

  logic [ZBT_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic                  zbt_we_q, zbt_we_d;
  logic [ZBT_ADDR_W-1:0] zbt_addr_q, zbt_addr_d;
  logic [PIX_PAIR_W-1:0] iss_dat_q, iss_dat_d;
  logic [ZBT_WR_LAT-1:0][PIX_PAIR_W-1:0] wdat_q, wdat_d;
  logic                  overflow_q, overflow_d;

  // Video timing never stalls: a capture that finds no room is dropped, not held.
  always_comb begin
    cap           = wr_enable && (proc_pix_addr != last_addr_q);
    pop           = !fifo_empty && !zbt_rd_slot;
    push          = cap && (!fifo_full_w || pop);
    drop          = cap && !push;
    push_ent.addr = proc_pix_addr;
    push_ent.data = two_proc_pixs;
  end

  proc_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .pop_dat_o  (pop_ent),
    .full_o     (fifo_full_w),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    last_addr_d = cap ? proc_pix_addr : last_addr_q;
    zbt_we_d    = pop;
    zbt_addr_d  = pop ? pop_ent.addr : zbt_addr_q;
    iss_dat_d   = pop ? pop_ent.data : '0;
    overflow_d  = overflow_q | drop;
    // Data trails the strobe by the ZBT write latency; idle slots carry zero.
    wdat_d      = '0;
    wdat_d[0]   = iss_dat_q;
    for (int i = 1; i < ZBT_WR_LAT; i++) begin
      wdat_d[i] = wdat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= ADDR_NONE;
      zbt_we_q    <= 1'b0;
      zbt_addr_q  <= '0;
      iss_dat_q   <= '0;
      wdat_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      zbt_we_q    <= zbt_we_d;
      zbt_addr_q  <= zbt_addr_d;
      iss_dat_q   <= iss_dat_d;
      wdat_q      <= wdat_d;
      overflow_q  <= overflow_d;
    end
  end

  assign zbt_we    = zbt_we_q;
  assign zbt_addr  = zbt_addr_q;
  assign zbt_wdata = wdat_q[ZBT_WR_LAT-1];
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;

`ifdef PROC_WR_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset) fifo_cnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_proc_zbt_writer.sv
// Directed bench for proc_zbt_writer: cycle table plus hand sequences for freeze and reset.
module tb_proc_zbt_writer;
  import proc_zbt_writer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] two_proc_pixs;
  logic [18:0] proc_pix_addr;
  logic        wr_enable;
  logic        zbt_rd_slot;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        fifo_full;
  logic        overflow;
`ifdef PROC_WR_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  proc_zbt_writer #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .two_proc_pixs (two_proc_pixs),
    .proc_pix_addr (proc_pix_addr),
    .wr_enable     (wr_enable),
    .zbt_rd_slot   (zbt_rd_slot),
    .zbt_addr      (zbt_addr),
    .zbt_we        (zbt_we),
    .zbt_wdata     (zbt_wdata),
    .fifo_full     (fifo_full),
    .overflow      (overflow)
`ifdef PROC_WR_DROPCNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        en;
    logic        rs;
    logic [18:0] a;
    logic [35:0] d;
    logic        e_we;
    logic [18:0] e_addr;
    logic [35:0] e_wd;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(logic en, logic rs, logic [18:0] a, logic [35:0] d,
                              logic we, logic [18:0] ea, logic [35:0] ew, logic f, logic o);
    vec_t v;
    v.en = en; v.rs = rs; v.a = a; v.d = d;
    v.e_we = we; v.e_addr = ea; v.e_wd = ew; v.e_full = f; v.e_ovf = o;
    return v;
  endfunction

  function automatic logic [35:0] dat(int n);
    return {4'hC, 32'(n)};
  endfunction

  vec_t vt[30];

  initial begin
    int nwe;
    int at;
    logic [18:0] wa;
    logic [35:0] seen [12];
    logic [18:0] fa [$];

    // Expected outputs of row i are those seen after the clock edge that samples row i.
    vt[0]  = mk(1'b1, 1'b0, 19'h10, 36'h123456789, 1'b0, 19'h0,  36'h0,         1'b0, 1'b0);
    vt[1]  = mk(1'b1, 1'b0, 19'h10, 36'h123456789, 1'b1, 19'h10, 36'h0,         1'b0, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 19'h10, 36'h123456789, 1'b0, 19'h10, 36'h0,         1'b0, 1'b0);
    vt[3]  = mk(1'b1, 1'b0, 19'h10, 36'h123456789, 1'b0, 19'h10, 36'h123456789, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 1'b0, 19'h10, 36'h123456789, 1'b0, 19'h10, 36'h0,         1'b0, 1'b0);
    vt[5]  = mk(1'b1, 1'b1, 19'h1,  dat(1),  1'b0, 19'h10, 36'h0,   1'b0, 1'b0);
    vt[6]  = mk(1'b1, 1'b1, 19'h2,  dat(2),  1'b0, 19'h10, 36'h0,   1'b0, 1'b0);
    vt[7]  = mk(1'b1, 1'b1, 19'h3,  dat(3),  1'b0, 19'h10, 36'h0,   1'b0, 1'b0);
    vt[8]  = mk(1'b1, 1'b1, 19'h4,  dat(4),  1'b0, 19'h10, 36'h0,   1'b1, 1'b0);
    vt[9]  = mk(1'b1, 1'b1, 19'h5,  dat(5),  1'b0, 19'h10, 36'h0,   1'b1, 1'b1);
    vt[10] = mk(1'b1, 1'b1, 19'h6,  dat(6),  1'b0, 19'h10, 36'h0,   1'b1, 1'b1);
    vt[11] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b1, 19'h1,  36'h0,   1'b0, 1'b1);
    vt[12] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b1, 19'h2,  36'h0,   1'b0, 1'b1);
    vt[13] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b1, 19'h3,  dat(1),  1'b0, 1'b1);
    vt[14] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b1, 19'h4,  dat(2),  1'b0, 1'b1);
    vt[15] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b0, 19'h4,  dat(3),  1'b0, 1'b1);
    vt[16] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b0, 19'h4,  dat(4),  1'b0, 1'b1);
    vt[17] = mk(1'b1, 1'b0, 19'h6,  dat(6),  1'b0, 19'h4,  36'h0,   1'b0, 1'b1);
    vt[18] = mk(1'b1, 1'b1, 19'h7,  dat(7),  1'b0, 19'h4,  36'h0,   1'b0, 1'b1);
    vt[19] = mk(1'b1, 1'b1, 19'h8,  dat(8),  1'b0, 19'h4,  36'h0,   1'b0, 1'b1);
    vt[20] = mk(1'b1, 1'b1, 19'h9,  dat(9),  1'b0, 19'h4,  36'h0,   1'b0, 1'b1);
    vt[21] = mk(1'b1, 1'b1, 19'hA,  dat(10), 1'b0, 19'h4,  36'h0,   1'b1, 1'b1);
    vt[22] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b1, 19'h7,  36'h0,   1'b1, 1'b1);
    vt[23] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b1, 19'h8,  36'h0,   1'b0, 1'b1);
    vt[24] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b1, 19'h9,  dat(7),  1'b0, 1'b1);
    vt[25] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b1, 19'hA,  dat(8),  1'b0, 1'b1);
    vt[26] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b1, 19'hB,  dat(9),  1'b0, 1'b1);
    vt[27] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b0, 19'hB,  dat(10), 1'b0, 1'b1);
    vt[28] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b0, 19'hB,  dat(11), 1'b0, 1'b1);
    vt[29] = mk(1'b1, 1'b0, 19'hB,  dat(11), 1'b0, 19'hB,  36'h0,   1'b0, 1'b1);

    // Reset held with random inputs: every output stays zero.
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      two_proc_pixs = {4'($urandom), $urandom};
      proc_pix_addr = 19'($urandom);
      wr_enable     = 1'($urandom);
      zbt_rd_slot   = 1'($urandom);
      tick();
      chk("reset_outputs", 64'({zbt_addr, zbt_we, zbt_wdata, fifo_full, overflow}), 64'h0);
    end
`ifdef PROC_WR_DROPCNT_EN
    chk("reset_drop_count", 64'(drop_count), 64'h0);
`endif
    wr_enable   = 1'b0;
    zbt_rd_slot = 1'b0;
    reset       = 1'b1;
    tick();

    // Single write, overflow/drain, and push+pop at full.
    for (int i = 0; i < 30; i++) begin
      wr_enable     = vt[i].en;
      zbt_rd_slot   = vt[i].rs;
      proc_pix_addr = vt[i].a;
      two_proc_pixs = vt[i].d;
      tick();
      chk($sformatf("row%0d_we", i),    64'(zbt_we),    64'(vt[i].e_we));
      chk($sformatf("row%0d_addr", i),  64'(zbt_addr),  64'(vt[i].e_addr));
      chk($sformatf("row%0d_wdata", i), 64'(zbt_wdata), 64'(vt[i].e_wd));
      chk($sformatf("row%0d_full", i),  64'(fifo_full), 64'(vt[i].e_full));
      chk($sformatf("row%0d_ovf", i),   64'(overflow),  64'(vt[i].e_ovf));
`ifdef PROC_WR_DROPCNT_EN
      if (i == 10 || i == 29) chk($sformatf("row%0d_drop_count", i), 64'(drop_count), 64'd2);
`endif
    end

    // Repeated address: one write carrying the first sample's data.
    nwe = 0; at = -1; wa = '0;
    wr_enable = 1'b1; zbt_rd_slot = 1'b0; proc_pix_addr = 19'h20;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) two_proc_pixs = 36'h2000 + 36'(c);
      tick();
      seen[c] = zbt_wdata;
      if (zbt_we) begin nwe++; at = c; wa = zbt_addr; end
    end
    chk("rep_we_count", 64'(nwe), 64'd1);
    chk("rep_addr", 64'(wa), 64'h20);
    chk("rep_data", (at >= 0 && at + 2 < 12) ? 64'(seen[at+2]) : 64'hDEAD, 64'h2000);

    // Freeze: queued entries still drain, new addresses are ignored.
    zbt_rd_slot = 1'b1;
    for (int c = 0; c < 3; c++) begin
      proc_pix_addr = 19'h30 + 19'(c);
      two_proc_pixs = dat(48 + c);
      tick();
    end
    wr_enable = 1'b0; zbt_rd_slot = 1'b0;
    for (int c = 0; c < 10; c++) begin
      proc_pix_addr = 19'h33 + 19'(c);
      tick();
      if (zbt_we) fa.push_back(zbt_addr);
    end
    chk("freeze_we_count", 64'(fa.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("freeze_addr%0d", k), (k < fa.size()) ? 64'(fa[k]) : 64'hDEAD, 64'(19'h30 + 19'(k)));

    // Mid-burst reset with two entries queued and a write in flight.
    wr_enable = 1'b1; zbt_rd_slot = 1'b1;
    proc_pix_addr = 19'h40; two_proc_pixs = dat(64); tick();
    proc_pix_addr = 19'h41; two_proc_pixs = dat(65); tick();
    zbt_rd_slot = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_reset_we", 64'(zbt_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({zbt_addr, zbt_we, zbt_wdata, fifo_full, overflow}), 64'h0);
    @(negedge clk);
    wr_enable = 1'b0;
    tick();
    reset = 1'b1;
    nwe = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (zbt_we) nwe++;
    end
    chk("post_reset_no_stale", 64'(nwe), 64'd0);
    chk("post_reset_ovf", 64'(overflow), 64'd0);
`ifdef PROC_WR_DROPCNT_EN
    chk("post_reset_drop_count", 64'(drop_count), 64'h0);
`endif

    // Out-of-frame address straight after reset is not captured; a real one is.
    wr_enable = 1'b1; proc_pix_addr = 19'h7FFFF; two_proc_pixs = dat(99);
    nwe = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (zbt_we) nwe++;
    end
    chk("addr_none_not_captured", 64'(nwe), 64'd0);
    proc_pix_addr = 19'h50; two_proc_pixs = dat(80);
    nwe = 0; wa = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (zbt_we) begin nwe++; wa = zbt_addr; end
    end
    chk("after_none_we_count", 64'(nwe), 64'd1);
    chk("after_none_addr", 64'(wa), 64'h50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
